fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 105 ++++++++++
 tb/tb_fetch_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   First-word-fall-through FIFO of {pc, instr} pairs sitting between the
//   fetch and decode stages. Entries live in registers; the head entry is
//   presented combinationally from registered state.
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   reset        : asynchronous, active-high reset (clears pointers, count, storage)
//   flush_F      : synchronous flush (branch taken); empties the queue at the edge
//   enq_valid_F  : fetch presents a pair
//   enq_pc_F     : PC of the presented instruction
//   enq_instr_F  : instruction word of the presented pair
//   enq_ready_F  : queue has room (depends on registered state only)
//   deq_valid_D  : head entry is valid
//   deq_pc_D     : head PC (0 when empty)
//   deq_instr_D  : head instruction (0 when empty)
//   deq_ready_D  : decode consumes the head this cycle
//   count_Q      : number of occupied entries
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 64,
    parameter int IW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_F,
    input  logic                       enq_valid_F,
    input  logic [AW-1:0]              enq_pc_F,
    input  logic [IW-1:0]              enq_instr_F,
    output logic                       enq_ready_F,
    output logic                       deq_valid_D,
    output logic [AW-1:0]              deq_pc_D,
    output logic [IW-1:0]              deq_instr_D,
    input  logic                       deq_ready_D,
    output logic [$clog2(DEPTH):0]     count_Q
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    logic [AW-1:0] mem_pc    [DEPTH];
    logic [IW-1:0] mem_instr [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic do_enq;
    logic do_deq;

    // Ready comes only from the registered count, so a full queue stays
    // closed even when decode pops in the same cycle.
    assign enq_ready_F = (count < DEPTH_C);
    assign deq_valid_D = (count != '0);
    assign count_Q     = count;

    assign do_enq = enq_valid_F & enq_ready_F;
    assign do_deq = deq_valid_D & deq_ready_D;

    // Head is forced to zero while empty so stale storage never leaks out.
    assign deq_pc_D    = deq_valid_D ? mem_pc[rd_ptr]    : '0;
    assign deq_instr_D = deq_valid_D ? mem_instr[rd_ptr] : '0;

    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // NOTE: storage is cleared on reset as well; this is cheap at these
            // depths and makes every register's post-reset value deterministic.
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else if (flush_F) begin
            // Flush wins over any enqueue/dequeue in the same cycle; storage
            // is left as is because it is unreachable once count is 0.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                mem_pc[wr_ptr]    <= enq_pc_F;
                mem_instr[wr_ptr] <= enq_instr_F;
                wr_ptr            <= wr_ptr + ONE_P;  // wraps modulo DEPTH
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Self-checking bench for fetch_queue (DEPTH=4, AW=64, IW=32). A small
//   queue model acts as scoreboard: accepted pairs are pushed when driven and
//   popped/compared when the DUT hands them to decode. A vector table covers
//   fill / full-push / drain; hand-written sequences cover streaming with
//   wrap, flush, empty pop, full-with-pop and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 64;
    localparam int IW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush_F;
    logic          enq_valid_F;
    logic [AW-1:0] enq_pc_F;
    logic [IW-1:0] enq_instr_F;
    logic          enq_ready_F;
    logic          deq_valid_D;
    logic [AW-1:0] deq_pc_D;
    logic [IW-1:0] deq_instr_D;
    logic          deq_ready_D;
    logic [CW-1:0] count_Q;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] sb_q [$];

    typedef struct {
        logic          fl;
        logic          ev;
        logic [AW-1:0] pc;
        logic          dr;
        int            exp_count;
        logic          exp_valid;
        logic          exp_ready;
        logic [AW-1:0] exp_head;
    } vec_t;

    vec_t vecs [9];

    fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush_F     (flush_F),
        .enq_valid_F (enq_valid_F),
        .enq_pc_F    (enq_pc_F),
        .enq_instr_F (enq_instr_F),
        .enq_ready_F (enq_ready_F),
        .deq_valid_D (deq_valid_D),
        .deq_pc_D    (deq_pc_D),
        .deq_instr_D (deq_instr_D),
        .deq_ready_D (deq_ready_D),
        .count_Q     (count_Q)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] pc);
        return pc[IW-1:0] ^ 32'hC0DE_1234;
    endfunction

    task automatic check(input string name, input logic [AW-1:0] act,
                         input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare every DUT output against the scoreboard's view of the queue.
    task automatic check_state(input string tag);
        int            sz;
        logic [AW-1:0] head;
        sz   = sb_q.size();
        head = (sz > 0) ? sb_q[0] : '0;
        check({tag, " count_Q"},     AW'(count_Q),     AW'(sz));
        check({tag, " deq_valid_D"}, AW'(deq_valid_D), AW'(sz > 0));
        check({tag, " enq_ready_F"}, AW'(enq_ready_F), AW'(sz < DEPTH));
        check({tag, " deq_pc_D"},    deq_pc_D,         head);
        check({tag, " deq_instr_D"}, AW'(deq_instr_D),
              (sz > 0) ? AW'(instr_of(head)) : '0);
    endtask

    // Called at a falling edge: drive inputs, settle, score the edge, then
    // sample outputs 1 ns after the rising edge.
    task automatic step(input string tag, input logic fl, input logic ev,
                        input logic [AW-1:0] pc, input logic dr);
        int sz;
        flush_F     = fl;
        enq_valid_F = ev;
        enq_pc_F    = pc;
        enq_instr_F = instr_of(pc);
        deq_ready_D = dr;
        #2;
        sz = sb_q.size();
        if (fl) begin
            sb_q.delete();
        end else begin
            if (dr && sz > 0) begin
                check({tag, " popped pc"}, deq_pc_D, sb_q[0]);
                void'(sb_q.pop_front());
            end
            if (ev && sz < DEPTH) sb_q.push_back(pc);
        end
        @(posedge clk);
        #1;
        check_state(tag);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 64'd0,  1'b0, 1, 1'b1, 1'b1, 64'd0};
        vecs[1] = '{1'b0, 1'b1, 64'd4,  1'b0, 2, 1'b1, 1'b1, 64'd0};
        vecs[2] = '{1'b0, 1'b1, 64'd8,  1'b0, 3, 1'b1, 1'b1, 64'd0};
        vecs[3] = '{1'b0, 1'b1, 64'd12, 1'b0, 4, 1'b1, 1'b0, 64'd0};
        vecs[4] = '{1'b0, 1'b1, 64'd16, 1'b0, 4, 1'b1, 1'b0, 64'd0};
        vecs[5] = '{1'b0, 1'b0, 64'd0,  1'b1, 3, 1'b1, 1'b1, 64'd4};
        vecs[6] = '{1'b0, 1'b0, 64'd0,  1'b1, 2, 1'b1, 1'b1, 64'd8};
        vecs[7] = '{1'b0, 1'b0, 64'd0,  1'b1, 1, 1'b1, 1'b1, 64'd12};
        vecs[8] = '{1'b0, 1'b0, 64'd0,  1'b1, 0, 1'b0, 1'b1, 64'd0};

        reset       = 1'b1;
        flush_F     = 1'b0;
        enq_valid_F = 1'b0;
        enq_pc_F    = '0;
        enq_instr_F = '0;
        deq_ready_D = 1'b0;

        // Reset state while reset is held (no edges relied upon).
        #20;
        check_state("reset");
        #30;
        reset = 1'b0;
        @(negedge clk);

        // Fill, full-push, drain from the table.
        for (int i = 0; i < 9; i++) begin
            step($sformatf("vec%0d", i), vecs[i].fl, vecs[i].ev, vecs[i].pc, vecs[i].dr);
            check($sformatf("vec%0d tbl count", i), AW'(count_Q), AW'(vecs[i].exp_count));
            check($sformatf("vec%0d tbl valid", i), AW'(deq_valid_D), AW'(vecs[i].exp_valid));
            check($sformatf("vec%0d tbl ready", i), AW'(enq_ready_F), AW'(vecs[i].exp_ready));
            check($sformatf("vec%0d tbl head", i),  deq_pc_D, vecs[i].exp_head);
        end

        // Streaming with pointer wrap: 10 pairs, count holds at 1.
        for (int i = 0; i < 10; i++) begin
            step("stream", 1'b0, 1'b1, 64'h18 + 64'(4 * i), 1'b1);
            check("stream count=1", AW'(count_Q), AW'(1));
        end
        step("stream drain", 1'b0, 1'b0, '0, 1'b1);

        // Flush with 3 queued, plus simultaneous enqueue and dequeue.
        step("pre-flush", 1'b0, 1'b1, 64'h40, 1'b0);
        step("pre-flush", 1'b0, 1'b1, 64'h44, 1'b0);
        step("pre-flush", 1'b0, 1'b1, 64'h48, 1'b0);
        step("flush", 1'b1, 1'b1, 64'h100, 1'b1);
        check("flush count", AW'(count_Q), AW'(0));
        check("flush valid", AW'(deq_valid_D), AW'(0));

        // Empty pop for 3 cycles, then single enqueue appears after one edge.
        for (int i = 0; i < 3; i++) step("empty pop", 1'b0, 1'b0, '0, 1'b1);
        step("enq 0x200", 1'b0, 1'b1, 64'h200, 1'b0);
        check("0x200 head", deq_pc_D, 64'h200);
        step("pop 0x200", 1'b0, 1'b0, '0, 1'b1);

        // Full queue with a simultaneous pop: enqueue is still refused.
        for (int i = 0; i < 4; i++) step("fill2", 1'b0, 1'b1, 64'h300 + 64'(4 * i), 1'b0);
        step("full+pop", 1'b0, 1'b1, 64'h3F0, 1'b1);
        check("full+pop count", AW'(count_Q), AW'(3));
        for (int i = 0; i < 3; i++) step("drain2", 1'b0, 1'b0, '0, 1'b1);

        // Asynchronous reset between edges with 2 entries queued.
        step("pre-rst", 1'b0, 1'b1, 64'h500, 1'b0);
        step("pre-rst", 1'b0, 1'b1, 64'h504, 1'b0);
        enq_valid_F = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        sb_q.delete();
        check_state("async rst");
        @(negedge clk);
        reset = 1'b0;
        step("post-rst", 1'b0, 1'b1, 64'h600, 1'b0);
        check("post-rst head", deq_pc_D, 64'h600);
        step("post-rst pop", 1'b0, 1'b0, '0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
